// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// The index width helper keeps the counter at least one bit wide.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// nibble-serial adder sequencer (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_ctrl_clooka.sv
// 4-bit carry-lookahead adder slice shared by the nibble-serial sequencer.
// All carries are computed directly from generate/propagate terms.
module clooka (
    output logic [3:0] s,
    output logic       c,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = a & b;
    assign p = a ^ b;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    assign c  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer adding/subtracting two WIDTH-bit operands one nibble per clock
// through a single clooka slice, with the carry held in a register.
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);

    localparam int N     = WIDTH / NIBBLE;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_width_check
            $fatal(1, "nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic             a_msb;
    logic             b_msb;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] b_sel;
    logic [3:0]       slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] work_next;

    // Subtraction is a + ~b + 1: invert b here, force the carry-in at launch.
    assign b_sel = bus.sub ? ~bus.op_b : bus.op_b;

    clooka u_slice (
        .s   (slice_s),
        .c   (slice_c),
        .a   (a_reg[NIBBLE-1:0]),
        .b   (b_reg[NIBBLE-1:0]),
        .cin (carry_reg)
    );

    // Partial result: each new nibble sum enters at the top and walks down,
    // so after N shifts the least significant nibble sits at the bottom.
    generate
        if (N > 1) begin : g_work
            logic [WIDTH-NIBBLE-1:0] work_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    work_reg <= '0;
                end else if (state == RUN) begin
                    work_reg <= work_next[WIDTH-1:NIBBLE];
                end
            end

            assign work_next = {slice_s, work_reg};
        end else begin : g_no_work
            assign work_next = slice_s;
        end
    endgenerate

    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg     <= bus.op_a;
                        b_reg     <= b_sel;
                        carry_reg <= bus.sub ? 1'b1 : bus.cin;
                        idx       <= '0;
                        a_msb     <= bus.op_a[WIDTH-1];
                        b_msb     <= b_sel[WIDTH-1];
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> NIBBLE;
                    b_reg     <= b_reg >> NIBBLE;
                    carry_reg <= slice_c;
                    idx       <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        sum_q  <= work_next;
                        cout_q <= slice_c;
                        ovf_q  <= (a_msb == b_msb) && (work_next[WIDTH-1] != a_msb);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH = 16, 8 and 4 with
// hand-computed expected results, latencies and handshake behaviour.
module tb_nibble_serial_adder_ctrl;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        c;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0;
    logic        start8 = 1'b0;
    logic        start4 = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    int          sel = 16;

    logic        obs_busy;
    logic        obs_done;
    logic [15:0] obs_sum;
    logic        obs_cout;
    logic        obs_ovf;

    int n_checks = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();

    assign bus16.start = start16;
    assign bus16.sub   = sub;
    assign bus16.cin   = cin;
    assign bus16.op_a  = op_a;
    assign bus16.op_b  = op_b;
    assign bus8.start  = start8;
    assign bus8.sub    = sub;
    assign bus8.cin    = cin;
    assign bus8.op_a   = op_a[7:0];
    assign bus8.op_b   = op_b[7:0];
    assign bus4.start  = start4;
    assign bus4.sub    = sub;
    assign bus4.cin    = cin;
    assign bus4.op_a   = op_a[3:0];
    assign bus4.op_b   = op_b[3:0];

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    nibble_serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    always_comb begin
        obs_busy = bus16.busy;
        obs_done = bus16.done;
        obs_sum  = bus16.sum;
        obs_cout = bus16.cout;
        obs_ovf  = bus16.ovf;
        if (sel == 8) begin
            obs_busy = bus8.busy;
            obs_done = bus8.done;
            obs_sum  = {8'h00, bus8.sum};
            obs_cout = bus8.cout;
            obs_ovf  = bus8.ovf;
        end else if (sel == 4) begin
            obs_busy = bus4.busy;
            obs_done = bus4.done;
            obs_sum  = {12'h000, bus4.sum};
            obs_cout = bus4.cout;
            obs_ovf  = bus4.ovf;
        end
    end

    // Launch one operation from a negedge and wait (bounded) for done.
    // lat counts rising edges after the start edge until done is seen.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c,
                          output logic [15:0] rs, output logic rc, output logic ro,
                          output int lat, output bit overlap, output bit busy_ok);
        sel = w; op_a = a; op_b = b; sub = s; cin = c;
        start16 = (w == 16); start8 = (w == 8); start4 = (w == 4);
        @(negedge clk);
        start16 = 1'b0; start8 = 1'b0; start4 = 1'b0;
        op_a = ~a; op_b = ~b; sub = ~s; cin = ~c;
        lat = 0; overlap = 1'b0; busy_ok = 1'b1;
        while (!obs_done && lat < 20) begin
            if (!obs_busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        overlap = obs_busy && obs_done;
        rs = obs_sum; rc = obs_cout; ro = obs_ovf;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus16.busy, bus16.done, bus16.cout, bus16.ovf} !== 4'b0000) begin
            n_miscompares++;
            $display("FAIL reset_flags16: got busy/done/cout/ovf=%b required 0000",
                     {bus16.busy, bus16.done, bus16.cout, bus16.ovf});
        end
        n_checks++;
        if (bus16.sum !== 16'h0000) begin
            n_miscompares++;
            $display("FAIL reset_sum16: got %h required 0000", bus16.sum);
        end
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus4.busy, bus4.done, bus4.sum} !== 16'h0000) begin
            n_miscompares++;
            $display("FAIL reset_w8_w4: got %h required 0000",
                     {bus8.busy, bus8.done, bus8.sum, bus4.busy, bus4.done, bus4.sum});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        vec_t v[3] = '{
            '{16, 16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0},
            '{16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}
        };
        logic [15:0] rs; logic rc, ro; int lat; bit ov, bok;
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].w, v[i].a, v[i].b, v[i].s, v[i].c, rs, rc, ro, lat, ov, bok);
            n_checks++;
            if ({rs, rc, ro} !== {v[i].sum, v[i].cout, v[i].ovf}) begin
                n_miscompares++;
                $display("FAIL add[%0d] sum/cout/ovf: got %h/%b/%b required %h/%b/%b",
                         i, rs, rc, ro, v[i].sum, v[i].cout, v[i].ovf);
            end
            n_checks++;
            if (lat !== 4 || ov || !bok) begin
                n_miscompares++;
                $display("FAIL add[%0d] timing: got lat=%0d overlap=%0b busy_ok=%0b required 4/0/1",
                         i, lat, ov, bok);
            end
        end
    endtask

    task automatic test_sub();
        vec_t v[3] = '{
            '{16, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            '{16, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
            '{16, 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0}
        };
        logic [15:0] rs; logic rc, ro; int lat; bit ov, bok;
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].w, v[i].a, v[i].b, v[i].s, v[i].c, rs, rc, ro, lat, ov, bok);
            n_checks++;
            if ({rs, rc, ro} !== {v[i].sum, v[i].cout, v[i].ovf}) begin
                n_miscompares++;
                $display("FAIL sub[%0d] sum/cout/ovf: got %h/%b/%b required %h/%b/%b",
                         i, rs, rc, ro, v[i].sum, v[i].cout, v[i].ovf);
            end
            n_checks++;
            if (lat !== 4 || ov || !bok) begin
                n_miscompares++;
                $display("FAIL sub[%0d] timing: got lat=%0d overlap=%0b busy_ok=%0b required 4/0/1",
                         i, lat, ov, bok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int first = -1;
        int second = -1;
        bit hold_ok = 1'b1;
        sel = 16; op_a = 16'h0001; op_b = 16'h0002; sub = 1'b0; cin = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222;
        while (k < 16 && second < 0) begin
            if (bus16.done) begin
                if (first < 0) begin
                    first = k;
                    n_checks++;
                    if ({bus16.sum, bus16.cout, bus16.ovf} !== {16'h0003, 1'b0, 1'b0}) begin
                        n_miscompares++;
                        $display("FAIL b2b_first_result: got %h/%b/%b required 0003/0/0",
                                 bus16.sum, bus16.cout, bus16.ovf);
                    end
                end else begin
                    second = k;
                end
            end else if (first >= 0 && bus16.sum !== 16'h0003) begin
                hold_ok = 1'b0;
            end
            if (first >= 0 && k == first + 1) start16 = 1'b0;
            @(negedge clk);
            k++;
        end
        start16 = 1'b0;
        n_checks++;
        if (first !== 4 || second - first !== 5) begin
            n_miscompares++;
            $display("FAIL b2b_spacing: got first=%0d second=%0d required 4 and 9", first, second);
        end
        n_checks++;
        if (!hold_ok) begin
            n_miscompares++;
            $display("FAIL b2b_sum_hold: got sum change before second done required hold 0003");
        end
        n_checks++;
        if (bus16.sum !== 16'h3333) begin
            n_miscompares++;
            $display("FAIL b2b_second_result: got %h required 3333", bus16.sum);
        end
    endtask

    task automatic test_reset_abort();
        bit no_done = 1'b1;
        logic [15:0] rs; logic rc, ro; int lat; bit ov, bok;
        sel = 16; op_a = 16'h0F0F; op_b = 16'h0101; sub = 1'b0; cin = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf} !== 20'h00000) begin
            n_miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                     bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf);
        end
        for (int i = 0; i < 8; i++) begin
            if (bus16.done || bus16.busy) no_done = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!no_done) begin
            n_miscompares++;
            $display("FAIL abort_no_done: got activity after abort required idle");
        end
        run_op(16, 16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, ov, bok);
        n_checks++;
        if ({rs, rc, ro} !== {16'h0100, 1'b0, 1'b0} || lat !== 4) begin
            n_miscompares++;
            $display("FAIL abort_recover: got %h/%b/%b lat=%0d required 0100/0/0 lat=4",
                     rs, rc, ro, lat);
        end
    endtask

    task automatic test_width_sweep();
        vec_t v[10] = '{
            '{4, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1},
            '{4, 16'h0009, 16'h0008, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1},
            '{4, 16'h0003, 16'h0005, 1'b1, 1'b0, 16'h000E, 1'b0, 1'b0},
            '{4, 16'h0008, 16'h0001, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b1},
            '{4, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{8, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1},
            '{8, 16'h00C8, 16'h0064, 1'b0, 1'b1, 16'h002D, 1'b1, 1'b0},
            '{8, 16'h0050, 16'h00B0, 1'b1, 1'b0, 16'h00A0, 1'b0, 1'b1},
            '{8, 16'h0080, 16'h0080, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0},
            '{8, 16'h00FF, 16'h00FF, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0}
        };
        logic [15:0] rs; logic rc, ro; int lat; bit ov, bok;
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].w, v[i].a, v[i].b, v[i].s, v[i].c, rs, rc, ro, lat, ov, bok);
            n_checks++;
            if ({rs, rc, ro} !== {v[i].sum, v[i].cout, v[i].ovf}) begin
                n_miscompares++;
                $display("FAIL sweep[%0d] w%0d sum/cout/ovf: got %h/%b/%b required %h/%b/%b",
                         i, v[i].w, rs, rc, ro, v[i].sum, v[i].cout, v[i].ovf);
            end
            n_checks++;
            if (lat !== v[i].w / 4 || ov || !bok) begin
                n_miscompares++;
                $display("FAIL sweep[%0d] w%0d timing: got lat=%0d overlap=%0b busy_ok=%0b required %0d/0/1",
                         i, v[i].w, lat, ov, bok, v[i].w / 4);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_abort();
        test_width_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule
